bsg_reg_if: RTL and testbench

BSG_REG_IF -- requirements
Module: bsg_reg_if

---
 rtl/bsg_pkg.sv | 18 +
 rtl/bsg_edge_det.sv | 22 ++
 rtl/bsg_reg_if.sv | 142 ++++++++++++++
 tb/tb_bsg_reg_if.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_pkg.sv
// Shared types and constants for the bsg register interface.
// Holds the FSM state encoding, control/status bit indices and offsets.
package bsg_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_t;

    localparam int CTRL_TXEN    = 0;
    localparam int CTRL_INTMSK  = 1;
    localparam int CTRL_INTFLAG = 2;
    localparam int STAT_BUSY    = 0;

    localparam int unsigned OFF_CTRL = 0;
    localparam int unsigned OFF_CH0  = 1;

endpackage

// File: rtl/bsg_edge_det.sv
// Registered falling-edge detector for the BUSY status bit.
// fall is high while the previous sample was 1 and the current input is 0.
module bsg_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign fall = d_q & ~d;

endmodule

// File: rtl/bsg_reg_if.sv
// Control/channel register block behind a valid/ready bus.
// Every accepted transfer gets a one-cycle rvalid response.
module bsg_reg_if
    import bsg_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               ADDR_W    = 8,
    parameter int               NUM_CH    = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     write,
    input  logic                     valid,
    output logic                     ready,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic                     err,
    output logic [2:0]               ctrl_o,
    input  logic [4:0]               status_i,
    output logic [NUM_CH*DATA_W-1:0] ch_data_o,
    output logic                     tx_start,
    output logic                     irq
);

    state_t            state;
    logic [2:0]        ctrl_q;
    logic [DATA_W-1:0] ch_q [NUM_CH];

    logic              busy;
    logic              fall;
    logic              accept;
    logic              ctrl_hit;
    logic              ch_hit;
    logic              ctrl_wr;
    logic              ch_wr;
    logic              flag_nxt;
    logic              msk_nxt;
    logic [31:0]       offs;
    logic [DATA_W-1:0] rd_val;

    bsg_edge_det u_busy_fall (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (status_i[STAT_BUSY]),
        .fall  (fall)
    );

    // offs wraps for addresses below BASE_ADDR, which then miss both decodes
    always_comb begin
        busy     = status_i[STAT_BUSY];
        offs     = 32'(addr) - 32'(BASE_ADDR);
        ctrl_hit = (offs == OFF_CTRL);
        ch_hit   = (offs >= OFF_CH0) && (offs <= 32'(NUM_CH));
        ready    = (state == ST_IDLE) &&
                   !(valid && write && ch_hit && busy);
        accept   = valid && ready;
        ctrl_wr  = accept && write && ctrl_hit;
        ch_wr    = accept && write && ch_hit;
    end

    always_comb begin
        rd_val = '0;
        if (ctrl_hit) begin
            rd_val[7:0] = {status_i, ctrl_q};
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_hit && offs == 32'(k) + OFF_CH0) begin
                rd_val = ch_q[k];
            end
        end
    end

    // a BUSY falling edge beats a W1C clear in the same cycle
    always_comb begin
        flag_nxt = ctrl_q[CTRL_INTFLAG];
        if (ctrl_wr && wdata[CTRL_INTFLAG]) begin
            flag_nxt = 1'b0;
        end
        if (fall) begin
            flag_nxt = 1'b1;
        end
        msk_nxt = ctrl_wr ? wdata[CTRL_INTMSK] : ctrl_q[CTRL_INTMSK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rvalid   <= 1'b0;
            rdata    <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            ctrl_q   <= '0;
            irq      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                ch_q[k] <= '0;
            end
        end else begin
            ctrl_q[CTRL_INTFLAG] <= flag_nxt;
            ctrl_q[CTRL_INTMSK]  <= msk_nxt;
            irq                  <= flag_nxt & msk_nxt;
            tx_start <= ctrl_wr && wdata[CTRL_TXEN] &&
                        !ctrl_q[CTRL_TXEN] && !busy;
            if (ctrl_wr) begin
                ctrl_q[CTRL_TXEN] <= wdata[CTRL_TXEN];
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_wr && offs == 32'(k) + OFF_CH0) begin
                    ch_q[k] <= wdata;
                end
            end
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_RESP;
                        rvalid <= 1'b1;
                        err    <= !(ctrl_hit || ch_hit);
                        rdata  <= write ? '0 : rd_val;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ctrl_o = ctrl_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_data_o[k*DATA_W +: DATA_W] = ch_q[k];
    end

endmodule

// File: tb/tb_bsg_reg_if.sv
// Randomized and directed bench for bsg_reg_if with a register-level model.
// The model tracks register contents and expected responses per cycle.
module tb_bsg_reg_if;

    logic        clk;
    logic        rst_n;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        write;
    logic        valid;
    logic        ready;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        err;
    logic [2:0]  ctrl_o;
    logic [4:0]  status_i;
    logic [15:0] ch_data_o;
    logic        tx_start;
    logic        irq;

    int n_chk;
    int n_pass;

    bsg_reg_if dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .wdata     (wdata),
        .write     (write),
        .valid     (valid),
        .ready     (ready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .err       (err),
        .ctrl_o    (ctrl_o),
        .status_i  (status_i),
        .ch_data_o (ch_data_o),
        .tx_start  (tx_start),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference state in register terms
    bit       m_txen, m_msk, m_flag, m_bprev, m_resp;
    bit [7:0] m_ch [2];
    bit       e_rvalid, e_err, e_tx, e_irq;
    bit [7:0] e_rdata;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit is_ch(input bit [7:0] a);
        return a >= 8'h11 && a <= 8'h12;
    endfunction

    function automatic bit exp_ready();
        return !m_resp && !(valid && write && is_ch(addr) && status_i[0]);
    endfunction

    task automatic model_reset();
        m_txen = 0; m_msk = 0; m_flag = 0; m_bprev = 0; m_resp = 0;
        m_ch[0] = 0; m_ch[1] = 0;
        e_rvalid = 0; e_err = 0; e_tx = 0; e_irq = 0; e_rdata = 0;
    endtask

    task automatic model_edge();
        bit busy, acc, fall, clr;
        bit [7:0] idx;
        busy = status_i[0];
        acc  = valid && exp_ready();
        fall = m_bprev && !busy;
        clr  = 0;
        e_rvalid = acc; e_err = 0; e_rdata = 0; e_tx = 0;
        if (acc) begin
            if (addr == 8'h10) begin
                if (write) begin
                    e_tx   = wdata[0] && !m_txen && !busy;
                    m_txen = wdata[0];
                    m_msk  = wdata[1];
                    clr    = wdata[2];
                end else begin
                    e_rdata = {status_i, m_flag, m_msk, m_txen};
                end
            end else if (is_ch(addr)) begin
                idx = addr - 8'h11;
                if (write) m_ch[idx[0]] = wdata;
                else e_rdata = m_ch[idx[0]];
            end else begin
                e_err = 1;
            end
        end
        if (fall) m_flag = 1;
        else if (clr) m_flag = 0;
        e_irq   = m_flag && m_msk;
        m_resp  = acc;
        m_bprev = busy;
    endtask

    task automatic check_outs(input string p);
        chk({p, "_rvalid"}, 32'(rvalid), 32'(e_rvalid));
        chk({p, "_err"}, 32'(err), 32'(e_err));
        chk({p, "_rdata"}, 32'(rdata), 32'(e_rdata));
        chk({p, "_tx"}, 32'(tx_start), 32'(e_tx));
        chk({p, "_irq"}, 32'(irq), 32'(e_irq));
        chk({p, "_ctrl"}, 32'(ctrl_o), 32'({m_flag, m_msk, m_txen}));
        chk({p, "_ch"}, 32'(ch_data_o), 32'({m_ch[1], m_ch[0]}));
    endtask

    task automatic step(input string p, input bit v, input bit w,
                        input bit [7:0] a, input bit [7:0] d,
                        input bit [4:0] st);
        valid = v; write = w; addr = a; wdata = d; status_i = st;
        #1;
        chk({p, "_ready"}, 32'(ready), 32'(exp_ready()));
        @(posedge clk);
        model_edge();
        #1;
        check_outs(p);
    endtask

    task automatic idle(input string p, input bit [4:0] st);
        step(p, 0, 0, 8'h00, 8'h00, st);
    endtask

    initial begin
        bit       b;
        bit [31:0] r;
        bit [7:0] a;
        n_chk = 0; n_pass = 0;
        valid = 0; write = 0; addr = 0; wdata = 0; status_i = 0;
        rst_n = 0;
        model_reset();
        #12;
        check_outs("rst");
        rst_n = 1;
        idle("post_rst", 5'h00);

        step("w37", 1, 1, 8'h11, 8'hA5, 5'h00);
        idle("w37r", 5'h00);
        step("r37", 1, 0, 8'h11, 8'h00, 5'h00);
        chk("req37_rdata", 32'(rdata), 32'h0000_00A5);
        idle("r37r", 5'h00);

        for (int i = 0; i < 3; i++) step("bw38", 1, 1, 8'h12, 8'h3C, 5'h01);
        step("bw38a", 1, 1, 8'h12, 8'h3C, 5'h00);
        idle("bw38r", 5'h01);
        step("br38", 1, 0, 8'h12, 8'h00, 5'h01);
        chk("req38_rvalid", 32'(rvalid), 32'h1);
        idle("br38r", 5'h00);

        step("tx39", 1, 1, 8'h10, 8'h01, 5'h00);
        chk("req39_pulse", 32'(tx_start), 32'h1);
        idle("tx39r", 5'h00);
        step("tx39b", 1, 1, 8'h10, 8'h01, 5'h00);
        idle("tx39br", 5'h00);

        step("im40", 1, 1, 8'h10, 8'h02, 5'h00);
        idle("im40r", 5'h01);
        idle("im40b", 5'h01);
        idle("im40f", 5'h00);
        chk("req40_irq", 32'(irq), 32'h1);
        step("cl40", 1, 1, 8'h10, 8'h06, 5'h00);
        idle("cl40r", 5'h01);
        step("co40", 1, 1, 8'h10, 8'h06, 5'h00);
        chk("req40_keep", 32'(ctrl_o[2]), 32'h1);
        idle("co40r", 5'h00);

        step("ms41", 1, 0, 8'h20, 8'h00, 5'h00);
        idle("ms41r", 5'h00);
        step("ms41w", 1, 1, 8'h0F, 8'hFF, 5'h00);
        idle("ms41wr", 5'h00);

        step("rs42", 1, 0, 8'h11, 8'h00, 5'h00);
        rst_n = 0;
        #1;
        model_reset();
        check_outs("rs42_now");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
        idle("rs42_rel", 5'h00);
        idle("rs42_rel2", 5'h00);

        b = 0;
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            if (r[31:30] == 2'b00) b = ~b;
            case (r[29:27])
                3'd0: a = 8'h10;
                3'd1: a = 8'h11;
                3'd2: a = 8'h12;
                3'd3: a = 8'h13;
                3'd4: a = 8'h0F;
                3'd5: a = 8'h10;
                default: a = r[7:0];
            endcase
            step("rnd", r[26] | r[25], r[24], a, r[15:8], {r[19:16], b});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
